bmp_pixel_unpack: RTL and testbench

BMP_PIXEL_UNPACK -- requirements
Module: bmp_pixel_unpack

---
 rtl/detect_pkg.sv | 18 +
 rtl/bmp_byte_fifo.sv | 53 +++++
 rtl/bmp_pixel_unpack.sv | 119 +++++++++++
 tb/tb_bmp_pixel_unpack.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared types and constants for the BMP pixel unpacker.
package detect_pkg;

    localparam int unsigned DIM_W     = 12;
    localparam int unsigned BUF_BYTES = 7;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Words per BMP row: ceil(3*W/4), evaluated at 14 bits so 3*4095+3 cannot wrap.
    function automatic logic [DIM_W-1:0] row_words(input logic [DIM_W-1:0] w);
        logic [13:0] bytes3;
        bytes3 = 14'(w) * 14'd3 + 14'd3;
        return bytes3[13:2];
    endfunction

endpackage

// File: rtl/bmp_byte_fifo.sv
// Seven-byte buffer: appends a 32-bit word (4 bytes), pops 3 bytes, or drops everything.
module bmp_byte_fifo
    import detect_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic [31:0] push_word,
    input  logic        pop,
    input  logic        flush,
    output logic [2:0]  count,
    output pixel_t      head
);

    logic [7:0] bytes_q [BUF_BYTES];
    logic [7:0] bytes_d [BUF_BYTES];
    logic [2:0] count_q, count_d;
    int         base;

    always_comb begin
        base = int'(count_q);
        for (int i = 0; i < BUF_BYTES; i++) bytes_d[i] = bytes_q[i];
        if (flush) begin
            base = 0;
        end else if (pop) begin
            for (int i = 0; i < BUF_BYTES - 3; i++) bytes_d[i] = bytes_q[i + 3];
            for (int i = BUF_BYTES - 3; i < BUF_BYTES; i++) bytes_d[i] = 8'h00;
            base = base - 3;
        end
        // A pushed word lands right after whatever survives the pop/flush.
        if (push) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                if (i >= base && i < base + 4) bytes_d[i] = push_word[8*(i-base) +: 8];
            end
            base = base + 4;
        end
        count_d = 3'(base);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= 3'd0;
            for (int i = 0; i < BUF_BYTES; i++) bytes_q[i] <= 8'h00;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < BUF_BYTES; i++) bytes_q[i] <= bytes_d[i];
        end
    end

    assign count = count_q;
    assign head  = {bytes_q[2], bytes_q[1], bytes_q[0]};

endmodule

// File: rtl/bmp_pixel_unpack.sv
// Unpacks BGR bytes from little-endian BMP pixel-array words into {R,G,B} pixels
// with frame/row sideband, discarding per-row padding.
module bmp_pixel_unpack
    import detect_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [DIM_W-1:0] IMG_WIDTH,
    input  logic [DIM_W-1:0] IMG_HEIGHT,
    input  logic [31:0]      DATA,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output pixel_t           PIX,
    output logic             PIX_VALID,
    input  logic             PIX_READY,
    output logic             SOF,
    output logic             EOL,
    output logic             EOF,
    output logic [DIM_W-1:0] X,
    output logic [DIM_W-1:0] Y,
    output logic             DONE
);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d, words_q, words_d;
    logic [2:0]       count;
    pixel_t           head;
    logic             word_xfer, pix_xfer, at_eol, at_eof;

    bmp_byte_fifo u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (word_xfer),
        .push_word (DATA),
        .pop       (pix_xfer),
        .flush     (pix_xfer && at_eol),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        at_eol     = (x_q == width_q - 12'd1);
        at_eof     = at_eol && (y_q == height_q - 12'd1);
        // Ready depends only on registered state, never on PIX_READY.
        DATA_READY = (state_q == RUN) && (count <= 3'd3) && (words_q != '0);
        PIX_VALID  = (state_q == RUN) && (count >= 3'd3);
        word_xfer  = DATA_VALID && DATA_READY;
        pix_xfer   = PIX_VALID && PIX_READY;
        PIX        = PIX_VALID ? head : '0;
        SOF        = PIX_VALID && (x_q == '0) && (y_q == '0);
        EOL        = PIX_VALID && at_eol;
        EOF        = PIX_VALID && at_eof;
        X          = x_q;
        Y          = y_q;
        DONE       = (state_q == FIN);
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        x_d      = x_q;
        y_d      = y_q;
        words_d  = words_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    width_d  = IMG_WIDTH;
                    height_d = IMG_HEIGHT;
                    x_d      = '0;
                    y_d      = '0;
                    words_d  = row_words(IMG_WIDTH);
                    state_d  = (IMG_WIDTH != '0 && IMG_HEIGHT != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (word_xfer) words_d = words_q - 12'd1;
                if (pix_xfer) begin
                    if (at_eol) begin
                        x_d     = '0;
                        y_d     = at_eof ? '0 : y_q + 12'd1;
                        words_d = row_words(width_q);
                        if (at_eof) state_d = FIN;
                    end else begin
                        x_d = x_q + 12'd1;
                    end
                end
            end
            FIN: begin
                x_d     = '0;
                y_d     = '0;
                words_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
            words_q  <= words_d;
        end
    end

endmodule

// File: tb/tb_bmp_pixel_unpack.sv
// Directed self-checking bench for bmp_pixel_unpack.
module tb_bmp_pixel_unpack;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [11:0] IMG_WIDTH = '0;
    logic [11:0] IMG_HEIGHT = '0;
    logic [31:0] DATA = '0;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic [23:0] PIX;
    logic        PIX_VALID;
    logic        PIX_READY = 1'b0;
    logic        SOF, EOL, EOF, DONE;
    logic [11:0] X, Y;

    bmp_pixel_unpack dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PIX        (PIX),
        .PIX_VALID  (PIX_VALID),
        .PIX_READY  (PIX_READY),
        .SOF        (SOF),
        .EOL        (EOL),
        .EOF        (EOF),
        .X          (X),
        .Y          (Y),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] pix;
        logic        sof, eol, eof;
        logic [11:0] x, y;
    } obs_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] words [16];
    int          n_words;
    obs_t        pix_log[$];
    int          words_acc, done_cycles, done_first, done_gap, pv_cycles, dr_cycles;
    int          ready_viol, stall_changes, timed_out;
    logic [23:0] stall_pix;

    // Runs one frame from START, logging every pixel transfer and handshake statistics.
    task automatic run_frame(input logic [11:0] w, input logic [11:0] h, input int stall_len,
                             input int stop_pix, input int restart_pix, input logic [11:0] rw);
        int   widx = 0;
        int   mcount = 0;
        int   stalled = 0;
        int   eof_cyc = -1;
        int   after = 0;
        bit   restarted = 0;
        bit   wx;
        obs_t o;
        pix_log.delete();
        words_acc = 0; done_cycles = 0; done_first = -1; done_gap = -1;
        pv_cycles = 0; dr_cycles = 0; ready_viol = 0; stall_changes = 0;
        stall_pix = '0; timed_out = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (cyc == 0) begin
                START = 1'b1; IMG_WIDTH = w; IMG_HEIGHT = h;
            end else if (restart_pix >= 0 && !restarted && pix_log.size() == restart_pix) begin
                START = 1'b1; IMG_WIDTH = rw; restarted = 1;
            end
            DATA_VALID = (widx < n_words);
            DATA = (widx < n_words) ? words[widx] : 32'h0;
            PIX_READY = 1'b1;
            #1;
            if (PIX_VALID) begin
                pv_cycles++;
                if (stalled < stall_len) begin
                    PIX_READY = 1'b0;
                    if (stalled == 0) stall_pix = PIX;
                    else if (PIX !== stall_pix) stall_changes++;
                    stalled++;
                end
            end
            #1;
            if (DATA_READY) dr_cycles++;
            if (DATA_READY && mcount > 3) ready_viol++;
            if (DONE) begin
                done_cycles++;
                if (done_first < 0) begin
                    done_first = cyc;
                    done_gap = cyc - eof_cyc;
                end
            end
            wx = DATA_VALID && DATA_READY;
            if (wx) begin
                widx++; words_acc++;
            end
            if (PIX_VALID && PIX_READY) begin
                o.pix = PIX; o.sof = SOF; o.eol = EOL; o.eof = EOF; o.x = X; o.y = Y;
                pix_log.push_back(o);
                if (EOL) mcount = wx ? 4 : 0;
                else mcount = mcount + (wx ? 4 : 0) - 3;
                if (EOF) eof_cyc = cyc;
            end else if (wx) begin
                mcount += 4;
            end
            if (done_cycles > 0) after++;
            if (after >= 3 || (stop_pix > 0 && pix_log.size() == stop_pix)) begin
                timed_out = 0;
                break;
            end
        end
        @(posedge CLK);
        #1;
        START = 1'b0; DATA_VALID = 1'b0; PIX_READY = 1'b0;
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        #2;
        checks++; if (DATA_READY !== 1'b0) begin errors++;
            $display("FAIL reset_data_ready: got %b expected 0", DATA_READY); end
        checks++; if (PIX_VALID !== 1'b0) begin errors++;
            $display("FAIL reset_pix_valid: got %b expected 0", PIX_VALID); end
        checks++; if (PIX !== 24'h0) begin errors++;
            $display("FAIL reset_pix: got %h expected 000000", PIX); end
        checks++; if ({SOF, EOL, EOF} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {SOF, EOL, EOF}); end
        checks++; if (DONE !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if ({X, Y} !== 24'h0) begin errors++;
            $display("FAIL reset_xy: got %h expected 000000", {X, Y}); end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_w4h1();
        logic [23:0] exp_pix [4];
        exp_pix[0] = 24'h030201; exp_pix[1] = 24'h060504;
        exp_pix[2] = 24'h090807; exp_pix[3] = 24'h0C0B0A;
        words[0] = 32'h04030201; words[1] = 32'h08070605; words[2] = 32'h0C0B0A09;
        n_words = 3;
        run_frame(12'd4, 12'd1, 0, 0, -1, 12'd0);
        checks++; if (timed_out !== 0) begin errors++;
            $display("FAIL w4h1_timeout: got %0d expected 0", timed_out); end
        checks++; if (pix_log.size() !== 4) begin errors++;
            $display("FAIL w4h1_count: got %0d expected 4", pix_log.size()); end
        while (pix_log.size() < 4) pix_log.push_back('0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (pix_log[i].pix !== exp_pix[i]) begin errors++;
                $display("FAIL w4h1_pix%0d: got %h expected %h", i, pix_log[i].pix, exp_pix[i]); end
            checks++; if (pix_log[i].x !== 12'(i)) begin errors++;
                $display("FAIL w4h1_x%0d: got %0d expected %0d", i, pix_log[i].x, i); end
        end
        checks++; if ({pix_log[0].sof, pix_log[1].sof} !== 2'b10) begin errors++;
            $display("FAIL w4h1_sof: got %b expected 10", {pix_log[0].sof, pix_log[1].sof}); end
        checks++; if ({pix_log[2].eol, pix_log[3].eol, pix_log[3].eof} !== 3'b011) begin errors++;
            $display("FAIL w4h1_eol_eof: got %b expected 011",
                     {pix_log[2].eol, pix_log[3].eol, pix_log[3].eof}); end
        checks++; if (words_acc !== 3) begin errors++;
            $display("FAIL w4h1_words: got %0d expected 3", words_acc); end
        checks++; if (done_gap !== 1 || done_cycles !== 1) begin errors++;
            $display("FAIL w4h1_done: got gap %0d cycles %0d expected gap 1 cycles 1",
                     done_gap, done_cycles); end
    endtask

    task automatic test_padding();
        words[0] = 32'hAA332211; words[1] = 32'hBB665544;
        n_words = 2;
        run_frame(12'd1, 12'd2, 0, 0, -1, 12'd0);
        checks++; if (pix_log.size() !== 2) begin errors++;
            $display("FAIL pad_count: got %0d expected 2", pix_log.size()); end
        while (pix_log.size() < 2) pix_log.push_back('0);
        checks++; if (pix_log[0].pix !== 24'h332211) begin errors++;
            $display("FAIL pad_pix0: got %h expected 332211", pix_log[0].pix); end
        checks++; if (pix_log[1].pix !== 24'h665544) begin errors++;
            $display("FAIL pad_pix1: got %h expected 665544", pix_log[1].pix); end
        checks++; if ({pix_log[0].eol, pix_log[0].eof, pix_log[1].eol, pix_log[1].eof} !== 4'b1011)
            begin errors++;
            $display("FAIL pad_flags: got %b expected 1011",
                     {pix_log[0].eol, pix_log[0].eof, pix_log[1].eol, pix_log[1].eof}); end
        checks++; if ({pix_log[1].x, pix_log[1].y} !== {12'd0, 12'd1}) begin errors++;
            $display("FAIL pad_xy1: got %0d,%0d expected 0,1", pix_log[1].x, pix_log[1].y); end
        checks++; if (words_acc !== 2) begin errors++;
            $display("FAIL pad_words: got %0d expected 2", words_acc); end
        checks++; if (done_cycles !== 1) begin errors++;
            $display("FAIL pad_done: got %0d expected 1", done_cycles); end
    endtask

    task automatic test_backpressure();
        words[0] = 32'h04030201; words[1] = 32'h08070605; words[2] = 32'h0C0B0A09;
        words[3] = 32'hDEADBEEF;
        n_words = 4;
        run_frame(12'd3, 12'd1, 5, 0, -1, 12'd0);
        checks++; if (stall_pix !== 24'h030201 || stall_changes !== 0) begin errors++;
            $display("FAIL bp_stable: got %h changes %0d expected 030201 changes 0",
                     stall_pix, stall_changes); end
        checks++; if (ready_viol !== 0) begin errors++;
            $display("FAIL bp_ready_full: got %0d expected 0", ready_viol); end
        checks++; if (words_acc !== 3) begin errors++;
            $display("FAIL bp_words: got %0d expected 3", words_acc); end
        checks++; if (pix_log.size() !== 3) begin errors++;
            $display("FAIL bp_count: got %0d expected 3", pix_log.size()); end
        while (pix_log.size() < 3) pix_log.push_back('0);
        checks++; if (pix_log[1].pix !== 24'h060504 || pix_log[2].pix !== 24'h090807) begin
            errors++;
            $display("FAIL bp_pix: got %h %h expected 060504 090807",
                     pix_log[1].pix, pix_log[2].pix); end
        checks++; if (pix_log[2].eof !== 1'b1 || done_cycles !== 1) begin errors++;
            $display("FAIL bp_end: got eof %b done %0d expected 1 1",
                     pix_log[2].eof, done_cycles); end
    endtask

    task automatic test_zero_dim();
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        n_words = 2;
        run_frame(12'd0, 12'd5, 0, 0, -1, 12'd0);
        checks++; if (pv_cycles !== 0) begin errors++;
            $display("FAIL zero_pix_valid: got %0d expected 0", pv_cycles); end
        checks++; if (dr_cycles !== 0) begin errors++;
            $display("FAIL zero_data_ready: got %0d expected 0", dr_cycles); end
        checks++; if (done_first !== 1 || done_cycles !== 1) begin errors++;
            $display("FAIL zero_done: got first %0d cycles %0d expected 1 1",
                     done_first, done_cycles); end
    endtask

    task automatic test_reset_mid_frame();
        words[0] = 32'h04030201; words[1] = 32'h08070605; words[2] = 32'h0C0B0A09;
        words[3] = 32'h14131211; words[4] = 32'h18171615; words[5] = 32'h1C1B1A19;
        n_words = 6;
        run_frame(12'd4, 12'd2, 0, 3, -1, 12'd0);
        checks++; if (pix_log.size() !== 3 || done_cycles !== 0) begin errors++;
            $display("FAIL rst_partial: got %0d pixels done %0d expected 3 0",
                     pix_log.size(), done_cycles); end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++; if ({DATA_READY, PIX_VALID, SOF, EOL, EOF, DONE} !== 6'b0) begin errors++;
            $display("FAIL rst_mid_ctrl: got %b expected 000000",
                     {DATA_READY, PIX_VALID, SOF, EOL, EOF, DONE}); end
        checks++; if ({PIX, X, Y} !== 48'h0) begin errors++;
            $display("FAIL rst_mid_data: got %h expected 0", {PIX, X, Y}); end
        @(negedge CLK);
        RESET = 1'b0;
        run_frame(12'd4, 12'd2, 0, 0, -1, 12'd0);
        checks++; if (pix_log.size() !== 8) begin errors++;
            $display("FAIL rst_count: got %0d expected 8", pix_log.size()); end
        while (pix_log.size() < 8) pix_log.push_back('0);
        checks++; if ({pix_log[0].sof, pix_log[0].x, pix_log[0].y} !== 25'h1000000) begin errors++;
            $display("FAIL rst_first: got sof %b x %0d y %0d expected 1 0 0",
                     pix_log[0].sof, pix_log[0].x, pix_log[0].y); end
        checks++; if (pix_log[0].pix !== 24'h030201 || pix_log[4].pix !== 24'h131211) begin
            errors++;
            $display("FAIL rst_pix: got %h %h expected 030201 131211",
                     pix_log[0].pix, pix_log[4].pix); end
        checks++; if (pix_log[7].eof !== 1'b1 || pix_log[7].y !== 12'd1 || done_cycles !== 1)
            begin errors++;
            $display("FAIL rst_end: got eof %b y %0d done %0d expected 1 1 1",
                     pix_log[7].eof, pix_log[7].y, done_cycles); end
    endtask

    task automatic test_restart_ignored();
        words[0] = 32'h04030201; words[1] = 32'h88870605;
        words[2] = 32'h0C0B0A09; words[3] = 32'h99980E0D;
        words[4] = 32'h55555555; words[5] = 32'h66666666;
        n_words = 6;
        run_frame(12'd2, 12'd2, 0, 0, 1, 12'd4);
        checks++; if (pix_log.size() !== 4) begin errors++;
            $display("FAIL restart_count: got %0d expected 4", pix_log.size()); end
        while (pix_log.size() < 4) pix_log.push_back('0);
        checks++; if (pix_log[1].eol !== 1'b1 || pix_log[1].x !== 12'd1) begin errors++;
            $display("FAIL restart_eol: got eol %b x %0d expected 1 1",
                     pix_log[1].eol, pix_log[1].x); end
        checks++; if (pix_log[2].pix !== 24'h0B0A09 || pix_log[3].pix !== 24'h0E0D0C) begin
            errors++;
            $display("FAIL restart_pix: got %h %h expected 0B0A09 0E0D0C",
                     pix_log[2].pix, pix_log[3].pix); end
        checks++; if (pix_log[3].eof !== 1'b1 || words_acc !== 4 || done_cycles !== 1) begin
            errors++;
            $display("FAIL restart_end: got eof %b words %0d done %0d expected 1 4 1",
                     pix_log[3].eof, words_acc, done_cycles); end
    endtask

    initial begin
        test_reset();
        test_w4h1();
        test_padding();
        test_backpressure();
        test_zero_dim();
        test_reset_mid_frame();
        test_restart_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
